load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Multi-cycle data-memory access stage downstream of the execute/ALU path.
//   Takes address + store data + load/store control from the core, does byte/half/word
//   alignment, runs one request/ack transaction on the data-memory bus, and returns
//   sign/zero-extended load data (or a completion) for register writeback. Core stalls while req_ready=0.
// PARAMETERS
//   TIMEOUT_CYCLES  15  max bus_req cycles without bus_ack before error completion (1..255)
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous, active-high reset
//   req_valid    in   1   core presents an access
//   req_ready    out  1   LSU idle, accepts request this cycle
//   req_write    in   1   1=store, 0=load
//   req_addr     in   32  byte address (ALU result)
//   req_wdata    in   32  store data (rs2), LSBs significant
//   store_ctrl   in   2   00=SB 01=SH 10=SW 11=illegal
//   load_ctrl    in   3   000=LB 001=LH 010=LW 100=LBU 101=LHU, others illegal
//   bus_req      out  1   memory request, held until bus_ack
//   bus_we       out  1   write strobe
//   bus_addr     out  32  word-aligned address {req_addr[31:2],2'b00}
//   bus_be       out  4   byte enables
//   bus_wdata    out  32  lane-replicated store data
//   bus_ack      in   1   memory completes request this cycle; bus_rdata valid
//   bus_rdata    in   32  read word
//   rsp_valid    out  1   one-cycle completion pulse
//   rsp_rdata    out  32  extended load data (0 for stores/errors)
//   rsp_err      out  1   misaligned, illegal ctrl, or timeout (qualified by rsp_valid)
// BEHAVIOUR
//   - Reset: state IDLE, req_ready=1, all other outputs 0, timeout counter 0; async assert
//     drops bus_req immediately, even mid-transaction; no rsp for aborted access.
//   - FSM IDLE->WAIT->RESP->IDLE. req_ready=1 only in IDLE; accept = req_valid&req_ready;
//     all request fields registered on accept.
//   - IDLE: on accept with legal, aligned access -> WAIT; misaligned (SH/LH/LHU addr[0]=1,
//     SW/LW addr[1:0]!=0) or illegal ctrl -> RESP with err=1, no bus activity.
//   - WAIT: bus_req=1, bus_we/addr/be/wdata stable. bus_ack -> RESP, capture bus_rdata,
//     bus_req=0 next cycle. Counter increments each WAIT cycle without ack; when it reaches
//     TIMEOUT_CYCLES -> RESP with err=1. Ack in the same cycle as the limit: ack wins, err=0.
//   - RESP: rsp_valid=1 exactly one cycle, then IDLE (req_ready=1 the cycle after rsp).
//   - Latency: accept cycle N, bus_req N+1..M (ack at M), rsp_valid M+1. Min 2 cycles after accept.
//     Error rsp without bus: N+1.
//   - Stores: SB bus_be=4'b0001<<addr[1:0], wdata={4{b}}; SH bus_be=addr[1]?1100:0011,
//     wdata={2{h}}; SW be=1111, wdata=req_wdata. Loads: bus_be=1111, bus_we=0, bus_wdata=0.
//   - Loads: select byte addr[1:0] / half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
//   - bus_ack outside WAIT ignored. req_valid while busy ignored (not queued).
// TESTING
//   1 SW addr=0x100 data=0xDEADBEEF, ack 1 cycle later -> be=1111, wdata=0xDEADBEEF, rsp_valid
//     2 cycles after accept, err=0, rdata=0.
//   2 LB addr=0x103, bus_rdata=0x80FF7F01 -> rsp_rdata=0xFFFFFF80; LBU same -> 0x00000080;
//     LH addr=0x102 -> 0xFFFF80FF.
//   3 SH addr=0x101 -> no bus_req, rsp_valid next cycle with err=1; load_ctrl=3'b011 -> same.
//   4 LW with no ack, TIMEOUT_CYCLES=4 -> bus_req exactly 4 cycles, rsp err=1, rdata=0; repeat
//     with ack on 4th cycle -> err=0, data returned.
//   5 SB addr=0x202 data=0x12345678 -> be=0100, wdata=0x78787878; ack after 3 wait cycles ok.
//   6 assert rst during WAIT -> bus_req=0 immediately, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store stage with req/ack data-memory bus
//
// Purpose: accepts one access from the core while idle and registers it.
// Stores are aligned into byte lanes and loads are sign- or zero-extended.
// Each access runs one request/ack transaction on the data bus. Exactly one
// completion pulse returns per access; misaligned, illegal or timed-out
// accesses complete with an error.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   req_valid/req_ready         core handshake; ready only while idle
//   req_write, req_addr,        access type, byte address, store data,
//   req_wdata, store_ctrl,      store size (SB/SH/SW) and
//   load_ctrl                   load size/sign (LB/LH/LW/LBU/LHU)
//   bus_req/bus_ack             memory handshake; request held until ack
//   bus_we, bus_addr, bus_be,   write strobe, word address, byte enables,
//   bus_wdata, bus_rdata        lane-replicated store data, read word
//   rsp_valid, rsp_rdata,       one-cycle completion, extended load data,
//   rsp_err                     error flag (valid with rsp_valid)
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  store_ctrl,
    input  logic [2:0]  load_ctrl,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  lctrl_q, lctrl_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        acc_bad;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [7:0]  cnt_inc;

    // Decode the incoming request: lane enables, replicated store data, legality.
    always_comb begin
        acc_bad   = 1'b0;
        acc_be    = 4'b1111;
        acc_wdata = '0;
        if (req_write) begin
            case (store_ctrl)
                2'b00: begin
                    acc_be    = 4'b0001 << req_addr[1:0];
                    acc_wdata = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    acc_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                    acc_wdata = {2{req_wdata[15:0]}};
                    acc_bad   = req_addr[0];
                end
                2'b10: begin
                    acc_wdata = req_wdata;
                    acc_bad   = |req_addr[1:0];
                end
                default: acc_bad = 1'b1;
            endcase
        end else begin
            case (load_ctrl)
                3'b000, 3'b100: acc_bad = 1'b0;
                3'b001, 3'b101: acc_bad = req_addr[0];
                3'b010:         acc_bad = |req_addr[1:0];
                default:        acc_bad = 1'b1;
            endcase
        end
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (lctrl_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_ext = bus_rdata;
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = '0;
        endcase
    end

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        lctrl_d = lctrl_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_write;
                    addr_d  = req_addr;
                    be_d    = acc_be;
                    wdata_d = acc_wdata;
                    lctrl_d = load_ctrl;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = acc_bad;
                    // Bad accesses skip the bus entirely and complete next cycle.
                    state_d = acc_bad ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // Ack takes priority over the timeout in the same cycle.
                if (bus_ack) begin
                    rdata_d = we_q ? 32'd0 : ld_ext;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_inc == TO_LIMIT) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            lctrl_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            lctrl_q <= lctrl_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode directly from the state register so an async reset
    // drops bus_req in the same instant.
    assign req_ready = (state_q == S_IDLE);
    assign bus_req   = (state_q == S_WAIT);
    assign bus_we    = bus_req & we_q;
    assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_be    = bus_req ? be_q : 4'd0;
    assign bus_wdata = bus_req ? wdata_q : 32'd0;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  store_ctrl;
    logic [2:0]  load_ctrl;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .store_ctrl(store_ctrl), .load_ctrl(load_ctrl),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic        chk_en = 1'b0;
    logic        exp_ready, exp_bus_req, exp_we, exp_rsp_valid, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("bus_req",   32'(bus_req),   32'(exp_bus_req));
            chk("bus_we",    32'(bus_we),    32'(exp_we));
            chk("bus_addr",  bus_addr,       exp_addr);
            chk("bus_be",    32'(bus_be),    32'(exp_be));
            chk("bus_wdata", bus_wdata,      exp_wdata);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            if (exp_rsp_valid) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_err",   32'(rsp_err), 32'(exp_err));
            end
        end
    end

    // Reference: access size in bytes, legality by divisibility, lanes by arithmetic.
    function automatic void model_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                      input logic [1:0] sc, input logic [2:0] lc,
                                      output logic bad, output logic [3:0] be, output logic [31:0] bwd);
        int size;
        logic [31:0] d;
        if (wr) begin
            size = (sc == 2'd0) ? 1 : (sc == 2'd1) ? 2 : 4;
            bad  = (sc == 2'd3) || ((a % size) != 0);
            be   = 4'(((1 << size) - 1) << (a % 4));
            d    = (size == 4) ? wd : (wd & ((32'd1 << (8 * size)) - 32'd1));
            bwd  = (size == 1) ? d * 32'h01010101 : (size == 2) ? d * 32'h00010001 : d;
        end else begin
            size = (lc[1:0] == 2'd0) ? 1 : (lc[1:0] == 2'd1) ? 2 : 4;
            bad  = !(lc inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || ((a % size) != 0);
            be   = 4'hF;
            bwd  = 32'd0;
        end
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] lc, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (lc)
            3'd0: return 32'($signed(v[7:0]));
            3'd1: return 32'($signed(v[15:0]));
            3'd4: return {24'd0, v[7:0]};
            3'd5: return {16'd0, v[15:0]};
            default: return rd;
        endcase
    endfunction

    task automatic set_idle_exp();
        exp_ready = 1'b1; exp_bus_req = 1'b0; exp_we = 1'b0; exp_addr = '0;
        exp_be = '0; exp_wdata = '0; exp_rsp_valid = 1'b0; exp_err = 1'b0; exp_rdata = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            bus_ack   = 1'($urandom);
            bus_rdata = $urandom;
            set_idle_exp();
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
    endtask

    // ack_at: WAIT cycle index carrying the ack; >= TMO means no ack at all.
    task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sc, input logic [2:0] lc, input int ack_at,
                          input logic [31:0] rd, input logic use_lit, input logic [31:0] lit_rdata,
                          input logic lit_err, input logic [3:0] lit_be, input logic [31:0] lit_wdata);
        logic bad, got_ack;
        logic [3:0] be;
        logic [31:0] bwd;
        model_req(wr, a, wd, sc, lc, bad, be, bwd);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        store_ctrl = sc; load_ctrl = lc;
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        set_idle_exp();
        @(posedge clk); #1;
        req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; store_ctrl = 2'($urandom); load_ctrl = 3'($urandom);
        got_ack = 1'b0;
        if (!bad) begin
            for (int k = 0; k < TMO; k++) begin
                exp_ready = 1'b0; exp_bus_req = 1'b1; exp_we = wr;
                exp_addr = {a[31:2], 2'b00}; exp_be = be; exp_wdata = bwd;
                exp_rsp_valid = 1'b0;
                bus_ack = (k == ack_at);
                bus_rdata = (k == ack_at) ? rd : $urandom;
                if (k == 0 && use_lit) begin
                    @(negedge clk); #1;
                    chk("lit_bus_be", 32'(bus_be), 32'(lit_be));
                    chk("lit_bus_wdata", bus_wdata, lit_wdata);
                end
                @(posedge clk); #1;
                if (k == ack_at) begin
                    got_ack = 1'b1;
                    break;
                end
            end
        end
        set_idle_exp();
        exp_ready = 1'b0; exp_rsp_valid = 1'b1;
        exp_err   = bad || !got_ack;
        exp_rdata = (exp_err || wr) ? 32'd0 : model_load(lc, a, rd);
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        if (use_lit) begin
            @(negedge clk); #1;
            chk("lit_rdata", rsp_rdata, lit_rdata);
            chk("lit_err", 32'(rsp_err), 32'(lit_err));
        end
        @(posedge clk); #1;
        req_valid = 1'b0; bus_ack = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        store_ctrl = '0; load_ctrl = '0; bus_ack = 1'b0; bus_rdata = '0;
        set_idle_exp();
        chk_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // SW, ack on first bus cycle
        do_txn(1, 32'h100, 32'hDEADBEEF, 2'b10, 3'd0, 0, 32'h0, 1, 32'h0, 0, 4'b1111, 32'hDEADBEEF);
        idle(1);
        // byte/half loads and extension
        do_txn(0, 32'h103, 32'h0, 2'b00, 3'b000, 0, 32'h80FF7F01, 1, 32'hFFFFFF80, 0, 4'hF, 32'h0);
        do_txn(0, 32'h103, 32'h0, 2'b00, 3'b100, 1, 32'h80FF7F01, 1, 32'h00000080, 0, 4'hF, 32'h0);
        do_txn(0, 32'h102, 32'h0, 2'b00, 3'b001, 2, 32'h80FF7F01, 1, 32'hFFFF80FF, 0, 4'hF, 32'h0);
        // misaligned store and illegal load ctrl: no bus cycle, error next cycle
        do_txn(1, 32'h101, 32'h5555, 2'b01, 3'd0, 0, 32'h0, 1, 32'h0, 1, 4'h0, 32'h0);
        do_txn(0, 32'h100, 32'h0, 2'b00, 3'b011, 0, 32'h0, 1, 32'h0, 1, 4'h0, 32'h0);
        // timeout, then ack on the last allowed cycle
        do_txn(0, 32'h300, 32'h0, 2'b00, 3'b010, TMO, 32'h0, 1, 32'h0, 1, 4'hF, 32'h0);
        do_txn(0, 32'h300, 32'h0, 2'b00, 3'b010, TMO - 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 0, 4'hF, 32'h0);
        // SB lane replication, ack after 3 wait cycles
        do_txn(1, 32'h202, 32'h12345678, 2'b00, 3'd0, 3, 32'h0, 1, 32'h0, 0, 4'b0100, 32'h78787878);
        idle(1);

        // reset in the middle of a bus transaction
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h400; load_ctrl = 3'b010;
        set_idle_exp();
        @(posedge clk); #1;
        req_valid = 1'b0; bus_ack = 1'b0;
        exp_ready = 1'b0; exp_bus_req = 1'b1; exp_be = 4'hF; exp_addr = 32'h400;
        @(posedge clk); #1;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_bus_req_drop", 32'(bus_req), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        set_idle_exp();
        bus_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);

        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            a = {20'h0, 10'($urandom), 2'($urandom)};
            do_txn(1'($urandom), a, $urandom, 2'($urandom), 3'($urandom),
                   int'($urandom_range(0, TMO + 1)), $urandom, 0, 32'h0, 0, 4'h0, 32'h0);
            if (($urandom % 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
